// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle control FSM with NZCV condition evaluation
module mc_ctrl_fsm #(
  parameter logic [3:0] INIT_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic        Src_64b,
  output logic        FPUWrite,
  output logic        RegSrc64b,
  output logic [3:0]  Flags
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTER,
    S_EXECUTEI, S_ALUWB, S_BRANCH, S_MUL64, S_MUL64WB, S_FPUEX, S_FPUWB
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cond;
  logic       is_lmul, is_fpu, is_logic, cond_ex;
  logic [2:0] dp_alu;
  logic       pc_we, mem_we, reg_we, ir_we, fpu_we;
  logic       unused_instr;

  assign op       = Instr[27:26];
  assign funct    = Instr[25:20];
  assign cond     = Instr[31:28];
  assign is_lmul  = (Instr[27:23] == 5'b00001) && (Instr[7:4] == 4'b1001);
  assign is_fpu   = (Instr[27:24] == 4'b1110) && (Instr[11:9] == 3'b101);
  assign is_logic = (funct[4:1] == 4'b0000) || (funct[4:1] == 4'b1100);
  assign unused_instr = ^{Instr[19:12], Instr[8], Instr[3:0]};

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    dp_alu = 3'b000;
    case (funct[4:1])
      4'b0010: dp_alu = 3'b001;
      4'b0000: dp_alu = 3'b010;
      4'b1100: dp_alu = 3'b011;
      default: dp_alu = 3'b000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    pc_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    ir_we      = 1'b0;
    fpu_we     = 1'b0;
    AdrSrc     = 1'b0;
    RegSrc     = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 2'b00;
    ALUControl = 3'b000;
    Src_64b    = 1'b0;
    RegSrc64b  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_we     = 1'b1;
        pc_we     = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (op == 2'b01) RegSrc = 2'b10;
        if (is_lmul)                         state_d = S_MUL64;
        else if (is_fpu)                     state_d = S_FPUEX;
        else if (op == 2'b01)                state_d = S_MEMADR;
        else if (op == 2'b10)                state_d = S_BRANCH;
        else if (op == 2'b00 && funct[5])    state_d = S_EXECUTEI;
        else if (op == 2'b00)                state_d = S_EXECUTER;
        else                                 state_d = S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_we    = cond_ex;
        ResultSrc = 2'b01;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        mem_we  = cond_ex;
        state_d = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUControl = dp_alu;
        if (state_q == S_EXECUTEI) ALUSrcB = 2'b01;
        // Logical ops have no carry/overflow of their own, so C and V are kept.
        if (funct[0] && cond_ex)
          flags_d = is_logic ? {ALUFlags[3:2], flags_q[1:0]} : ALUFlags;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = cond_ex;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ResultSrc = 2'b10;
        pc_we     = cond_ex;
        state_d   = S_FETCH;
      end
      S_MUL64: begin
        RegSrc64b  = 1'b1;
        ALUControl = 3'b100;
        state_d    = S_MUL64WB;
      end
      S_MUL64WB: begin
        RegSrc64b = 1'b1;
        Src_64b   = 1'b1;
        reg_we    = cond_ex;
        state_d   = S_FETCH;
      end
      S_FPUEX: state_d = S_FPUWB;
      S_FPUWB: begin
        fpu_we  = cond_ex;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= INIT_FLAGS;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  assign PCWrite  = pc_we  & ~reset;
  assign MemWrite = mem_we & ~reset;
  assign RegWrite = reg_we & ~reset;
  assign IRWrite  = ir_we  & ~reset;
  assign FPUWrite = fpu_we & ~reset;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic        Src_64b, FPUWrite, RegSrc64b;
  logic [3:0]  Flags;

  int checks = 0;
  int errors = 0;

  logic [20:0] V_FETCH, V_DEC, V_DEC_MEM;

  mc_ctrl_fsm #(.INIT_FLAGS(4'b0000)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .Src_64b(Src_64b), .FPUWrite(FPUWrite), .RegSrc64b(RegSrc64b), .Flags(Flags)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] v(input logic pcw, input logic mw, input logic rw,
                                    input logic irw, input logic adr, input logic [1:0] rsrc,
                                    input logic [1:0] asa, input logic [1:0] asb,
                                    input logic [1:0] rsl, input logic [1:0] imm,
                                    input logic [2:0] alu, input logic s64,
                                    input logic fpw, input logic r64);
    return {pcw, mw, rw, irw, adr, rsrc, asa, asb, rsl, imm, alu, s64, fpw, r64};
  endfunction

  function automatic logic [20:0] obs();
    return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
            ResultSrc, ImmSrc, ALUControl, Src_64b, FPUWrite, RegSrc64b};
  endfunction

  task automatic test_reset();
    reset = 1'b1; Instr = 32'h0; ALUFlags = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite} !== 5'b0) begin
      errors++; $display("FAIL reset_we got %b exp 00000", {PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", Flags); end
    checks++;
    if (obs() !== V_FETCH) begin errors++; $display("FAIL reset_fetch got %h exp %h", obs(), V_FETCH); end
  endtask

  task automatic test_add();
    logic [20:0] ex [4];
    ex = '{V_FETCH, V_DEC, v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0),
           v(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0)};
    Instr = 32'hE0821003; ALUFlags = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs() !== ex[i]) begin errors++; $display("FAIL add cyc%0d got %h exp %h", i, obs(), ex[i]); end
      @(posedge clk); #1;
    end
    checks++;
    if (Flags !== 4'b0000) begin errors++; $display("FAIL add_flags got %b exp 0000", Flags); end
  endtask

  task automatic test_flags_branch();
    logic [20:0] ex [4];
    logic [20:0] eb [3];
    ex = '{V_FETCH, V_DEC, v(0,0,0,0,0,2'b00,2'b00,2'b01,2'b00,2'b00,3'b001,0,0,0),
           v(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0)};
    Instr = 32'hE2500001; ALUFlags = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs() !== ex[i]) begin errors++; $display("FAIL subs cyc%0d got %h exp %h", i, obs(), ex[i]); end
      @(posedge clk); #1;
    end
    checks++;
    if (Flags !== 4'b0100) begin errors++; $display("FAIL subs_flags got %b exp 0100", Flags); end
    eb = '{V_FETCH, V_DEC, v(1,0,0,0,0,2'b00,2'b00,2'b01,2'b10,2'b10,3'b000,0,0,0)};
    Instr = 32'h0A000002; ALUFlags = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (obs() !== eb[i]) begin errors++; $display("FAIL beq_taken cyc%0d got %h exp %h", i, obs(), eb[i]); end
      @(posedge clk); #1;
    end
    #1; checks++;
    if (obs() !== V_FETCH) begin errors++; $display("FAIL beq_taken_next got %h exp %h", obs(), V_FETCH); end
  endtask

  task automatic test_branch_not_taken();
    logic [20:0] ex [4];
    logic [20:0] eb [3];
    ex = '{V_FETCH, V_DEC, v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0),
           v(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0)};
    Instr = 32'hE0900000; ALUFlags = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs() !== ex[i]) begin errors++; $display("FAIL adds0 cyc%0d got %h exp %h", i, obs(), ex[i]); end
      @(posedge clk); #1;
    end
    checks++;
    if (Flags !== 4'b0000) begin errors++; $display("FAIL adds0_flags got %b exp 0000", Flags); end
    eb = '{V_FETCH, V_DEC, v(0,0,0,0,0,2'b00,2'b00,2'b01,2'b10,2'b10,3'b000,0,0,0)};
    Instr = 32'h0A000002;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (obs() !== eb[i]) begin errors++; $display("FAIL beq_not cyc%0d got %h exp %h", i, obs(), eb[i]); end
      @(posedge clk); #1;
    end
    #1; checks++;
    if (obs() !== V_FETCH) begin errors++; $display("FAIL beq_not_next got %h exp %h", obs(), V_FETCH); end
  endtask

  task automatic test_ldr_str();
    logic [20:0] el [5];
    logic [20:0] es [4];
    el = '{V_FETCH, V_DEC_MEM, v(0,0,0,0,0,2'b00,2'b00,2'b01,2'b00,2'b01,3'b000,0,0,0),
           v(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0),
           v(0,0,1,0,0,2'b00,2'b00,2'b00,2'b01,2'b00,3'b000,0,0,0)};
    Instr = 32'hE5954008;
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (obs() !== el[i]) begin errors++; $display("FAIL ldr cyc%0d got %h exp %h", i, obs(), el[i]); end
      @(posedge clk); #1;
    end
    es = '{V_FETCH, V_DEC_MEM, v(0,0,0,0,0,2'b00,2'b00,2'b01,2'b00,2'b01,3'b000,0,0,0),
           v(0,1,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0)};
    Instr = 32'hE5854008;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs() !== es[i]) begin errors++; $display("FAIL str cyc%0d got %h exp %h", i, obs(), es[i]); end
      @(posedge clk); #1;
    end
    #1; checks++;
    if (obs() !== V_FETCH) begin errors++; $display("FAIL str_next got %h exp %h", obs(), V_FETCH); end
  endtask

  task automatic test_umull();
    logic [20:0] ex [4];
    ex = '{V_FETCH, V_DEC, v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b100,0,0,1),
           v(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,1,0,1)};
    Instr = 32'hE0832594;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs() !== ex[i]) begin errors++; $display("FAIL umull cyc%0d got %h exp %h", i, obs(), ex[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flags_logic();
    logic [20:0] ex [4];
    ex = '{V_FETCH, V_DEC, v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0),
           v(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0)};
    Instr = 32'hE0900000; ALUFlags = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs() !== ex[i]) begin errors++; $display("FAIL adds1 cyc%0d got %h exp %h", i, obs(), ex[i]); end
      @(posedge clk); #1;
    end
    checks++;
    if (Flags !== 4'b1111) begin errors++; $display("FAIL adds1_flags got %b exp 1111", Flags); end
    ex[2] = v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b010,0,0,0);
    Instr = 32'hE0100000; ALUFlags = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs() !== ex[i]) begin errors++; $display("FAIL ands cyc%0d got %h exp %h", i, obs(), ex[i]); end
      @(posedge clk); #1;
    end
    checks++;
    if (Flags !== 4'b0011) begin errors++; $display("FAIL ands_flags got %b exp 0011", Flags); end
    ex[2] = v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0);
    ex[3] = v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0);
    Instr = 32'h00900000; ALUFlags = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs() !== ex[i]) begin errors++; $display("FAIL addseq cyc%0d got %h exp %h", i, obs(), ex[i]); end
      @(posedge clk); #1;
    end
    checks++;
    if (Flags !== 4'b0011) begin errors++; $display("FAIL addseq_flags got %b exp 0011", Flags); end
  endtask

  task automatic test_cond_nv();
    logic [20:0] ex [4];
    ex = '{V_FETCH, V_DEC, v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0),
           v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0)};
    Instr = 32'hF0821003;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs() !== ex[i]) begin errors++; $display("FAIL cond_nv cyc%0d got %h exp %h", i, obs(), ex[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_undefined();
    logic [20:0] ex [2];
    ex = '{V_FETCH, V_DEC};
    Instr = 32'hEC000000;
    for (int i = 0; i < 2; i++) begin
      #1; checks++;
      if (obs() !== ex[i]) begin errors++; $display("FAIL undef cyc%0d got %h exp %h", i, obs(), ex[i]); end
      @(posedge clk); #1;
    end
    #1; checks++;
    if (obs() !== V_FETCH) begin errors++; $display("FAIL undef_next got %h exp %h", obs(), V_FETCH); end
  endtask

  task automatic test_fpu_reset();
    logic [20:0] ex [4];
    ex = '{V_FETCH, V_DEC, v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0),
           v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,0,1,0)};
    Instr = 32'hEE310A02;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs() !== ex[i]) begin errors++; $display("FAIL fpu cyc%0d got %h exp %h", i, obs(), ex[i]); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (obs() !== ex[i]) begin errors++; $display("FAIL fpu_abort cyc%0d got %h exp %h", i, obs(), ex[i]); end
      if (i == 2) reset = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if ({PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite} !== 5'b0) begin
      errors++; $display("FAIL fpu_abort_we got %b exp 00000", {PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1; checks++;
    if (obs() !== V_FETCH) begin errors++; $display("FAIL fpu_abort_fetch got %h exp %h", obs(), V_FETCH); end
    checks++;
    if (Flags !== 4'b0000) begin errors++; $display("FAIL fpu_abort_flags got %b exp 0000", Flags); end
    @(posedge clk); #1;
    checks++;
    if (obs() !== V_DEC) begin errors++; $display("FAIL fpu_abort_decode got %h exp %h", obs(), V_DEC); end
    @(posedge clk); #1;
    checks++;
    if (FPUWrite !== 1'b0) begin errors++; $display("FAIL fpu_abort_fpuex got %b exp 0", FPUWrite); end
  endtask

  initial begin
    V_FETCH   = v(1,0,0,1,0,2'b00,2'b01,2'b10,2'b10,2'b00,3'b000,0,0,0);
    V_DEC     = v(0,0,0,0,0,2'b00,2'b01,2'b10,2'b10,2'b00,3'b000,0,0,0);
    V_DEC_MEM = v(0,0,0,0,0,2'b10,2'b01,2'b10,2'b10,2'b00,3'b000,0,0,0);
    test_reset();
    test_add();
    test_flags_branch();
    test_branch_not_taken();
    test_ldr_str();
    test_umull();
    test_flags_logic();
    test_cond_nv();
    test_undefined();
    test_fpu_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control unit for the ARM-subset core with 64-bit long-multiply and FPU extensions.
- Sequences fetch, decode and execute for the shared-ALU datapath, and evaluates ARM condition codes against a registered NZCV flag set.
- Drives every datapath control input plus MemWrite to memory.
- Purely sequential Moore FSM plus a combinational condition check.

Parameters:
- INIT_FLAGS, 4'b0000, NZCV value loaded into the flag register on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- Instr  input  32  instruction register contents from the datapath.
- ALUFlags  input  4  datapath ALU flags {N,Z,C,V}.
- PCWrite  output  1  PC register enable.
- MemWrite  output  1  memory write strobe.
- RegWrite  output  1  integer register file write enable.
- IRWrite  output  1  instruction register enable.
- AdrSrc  output  1  memory address select: 0=PC, 1=result path.
- RegSrc  output  2  [0]: RA1=R15; [1]: RA2=Rd.
- ALUSrcA  output  2  00=A, 01=PC.
- ALUSrcB  output  2  00=WriteData, 01=ExtImm, 10=constant 4.
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult.
- ImmSrc  output  2  00=imm8, 01=imm12, 10=branch imm24.
- ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL64.
- Src_64b  output  1  register file writes the 64-bit multiply result.
- FPUWrite  output  1  FPU register file write enable.
- RegSrc64b  output  1  long-multiply register address remap.
- Flags  output  4  registered NZCV, for debug.

Behaviour:
- Decode fields:
  - Op = Instr[27:26]; Funct = Instr[25:20]; cond = Instr[31:28].
  - LMUL when Instr[27:23] = 5'b00001 and Instr[7:4] = 4'b1001.
  - FPU op when Instr[27:24] = 4'b1110 and Instr[11:9] = 3'b101.
  - Otherwise Op 00 = data-processing, 01 = memory, 10 = branch; Op 11 that is not an FPU op is undefined.
- CondEx is combinational from cond and Flags, using standard ARM EQ..AL semantics; cond 1111 counts as false.
- States and transitions:
  - FETCH -> DECODE.
  - DECODE:
    - -> MEMADR for memory ops.
    - -> EXECUTER for data-processing with Funct[5]=0.
    - -> EXECUTEI for data-processing with Funct[5]=1.
    - -> BRANCH for branches.
    - -> MUL64 for LMUL.
    - -> FPUEX for FPU ops.
    - -> FETCH for undefined.
  - MEMADR -> MEMRD if Funct[0]=1 (load), else -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
  - MUL64 -> MUL64WB -> FETCH.
  - FPUEX -> FPUWB -> FETCH.
- Outputs per state (any output not listed is 0):
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegSrc=2'b10 when Op=01.
  - MEMADR: ALUSrcB=01, ImmSrc=01.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: RegWrite=CondEx, ResultSrc=01.
  - MEMWR: AdrSrc=1, MemWrite=CondEx.
  - EXECUTER: ALUSrcB=00, ALUControl from Funct[4:1] (0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; other codes use ADD).
  - EXECUTEI: same as EXECUTER but ALUSrcB=01, ImmSrc=00.
  - ALUWB: RegWrite=CondEx, ResultSrc=00.
  - BRANCH: ALUSrcB=01, ImmSrc=10, ResultSrc=10, ALUControl=000, PCWrite=CondEx.
  - MUL64: RegSrc64b=1, ALUControl=100.
  - MUL64WB: RegSrc64b=1, Src_64b=1, RegWrite=CondEx.
  - FPUEX: no outputs asserted; one cycle for the FPU result register.
  - FPUWB: FPUWrite=CondEx.
- Latency in cycles, FETCH through the last state:
  - LDR 5; STR 4; data-processing 4; B 3; LMUL 4; FPU 4; undefined 2.
- Flags:
  - Register is loaded with ALUFlags at the end of EXECUTER/EXECUTEI when Funct[0]=1 and CondEx=1.
  - For AND/ORR only N and Z update; C and V are held.
  - Flags are never written in any other state.
- Condition evaluation: CondEx uses Flags as registered at the start of the state. A failed condition suppresses only write enables; the state sequence is unchanged.
- Reset:
  - While reset=1, all write enables (PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite) are forced to 0.
  - On the first edge with reset=0 the state is FETCH, and Flags=INIT_FLAGS.
  - Reset asserted mid-instruction aborts it: no partial writeback, and the FSM re-enters FETCH.

Test Plan:
- Reset, then ADD R1,R2,R3 (0xE0821003) -> states FETCH, DECODE, EXECUTER, ALUWB; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH; ALUControl=000.
- SUBS R0,R0,#1 (0xE2500001) with ALUFlags=4'b0100 during EXECUTEI -> Flags=0100 afterwards; a following BEQ (0x0A000002) -> PCWrite=1 in BRANCH, 3 cycles.
- With Flags=0000, BEQ 0x0A000002 -> PCWrite stays 0 in BRANCH; next state is FETCH.
- LDR R4,[R5,#8] (0xE5954008) -> 5 cycles; AdrSrc=1 in MEMRD; ResultSrc=01 with RegWrite=1 in MEMWB. STR (0xE5854008) -> MemWrite=1 in MEMWR, 4 cycles.
- UMULL R2,R3,R4,R5 (0xE0832594) -> MUL64 with ALUControl=100, then MUL64WB with Src_64b=1, RegSrc64b=1, RegWrite=1.
- FPU op 0xEE310A02 -> FPUEX, FPUWB with FPUWrite=1; assert reset during FPUEX -> FPUWrite never rises, FETCH follows release.
